// File: rtl/regex_char_sequencer.sv
// rtl/regex_char_sequencer.sv - byte FIFO and per-character sequencer in front of compiled_regex.
// Optional statistics counters are built when REGEX_SEQ_STATS_EN is defined.
module regex_char_sequencer #(
    parameter int FIFO_DEPTH   = 8,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 1024,
    parameter int POS_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    input  logic             in_eos,
    output logic             eng_start,
    output logic [7:0]       eng_char,
    output logic             eng_last,
    input  logic             eng_rdy,
    input  logic             eng_match,
    input  logic [POS_W-1:0] eng_start_pos,
    input  logic [POS_W-1:0] eng_end_pos,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_match,
    output logic             res_final,
    output logic [POS_W-1:0] res_start_pos,
    output logic [POS_W-1:0] res_end_pos,
    output logic             busy,
    output logic             timeout_err
`ifdef REGEX_SEQ_STATS_EN
    ,
    output logic [31:0]      stat_chars,
    output logic [15:0]      stat_matches
`endif
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int SCW = $clog2(START_CYCLES + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, KICK, WAIT, EMIT} state_t;

    state_t         state, state_next;
    logic [8:0]     mem [FIFO_DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr;
    logic [SCW-1:0] start_cnt;
    logic [TW-1:0]  to_cnt;
    logic           empty, full, push, pop;
    logic           capture, timed_out;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = reset & ~full;
    assign push     = in_valid & in_ready;
    assign pop      = (state == IDLE) & ~empty;
    assign busy     = (state != IDLE) | ~empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_eos, in_char};
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: if (!empty) state_next = KICK;
            KICK: if (start_cnt == SCW'(1)) state_next = WAIT;
            WAIT: begin
                if (eng_rdy) begin
                    if (eng_match || eng_last) begin
                        state_next = EMIT;
                        capture    = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                    state_next = IDLE;
                    timed_out  = 1'b1;
                end
            end
            EMIT: if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            start_cnt     <= '0;
            to_cnt        <= '0;
            eng_start     <= 1'b0;
            eng_char      <= '0;
            eng_last      <= 1'b0;
            res_valid     <= 1'b0;
            res_match     <= 1'b0;
            res_final     <= 1'b0;
            res_start_pos <= '0;
            res_end_pos   <= '0;
            timeout_err   <= 1'b0;
        end else begin
            state     <= state_next;
            eng_start <= (state_next == KICK);
            res_valid <= (state_next == EMIT);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                eng_char  <= mem[rd_ptr[AW-1:0]][7:0];
                eng_last  <= mem[rd_ptr[AW-1:0]][8];
                start_cnt <= SCW'(START_CYCLES);
            end else if (state == KICK) begin
                start_cnt <= start_cnt - 1'b1;
            end
            to_cnt <= (state == WAIT) ? to_cnt + 1'b1 : '0;
            // Positions are forced to zero on non-match records (e.g. the EOS record).
            if (capture) begin
                res_match     <= eng_match;
                res_final     <= eng_last;
                res_start_pos <= eng_match ? eng_start_pos : '0;
                res_end_pos   <= eng_match ? eng_end_pos : '0;
            end
            if (timed_out) begin
                timeout_err <= 1'b1;
            end
        end
    end

`ifdef REGEX_SEQ_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_chars   <= '0;
            stat_matches <= '0;
        end else begin
            if (state == WAIT && eng_rdy && !eng_last && !(&stat_chars)) begin
                stat_chars <= stat_chars + 1'b1;
            end
            if (capture && eng_match && !(&stat_matches)) begin
                stat_matches <= stat_matches + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/regex_char_sequencer.md
Name: regex_char_sequencer

Overview:
Upstream stage of compiled_regex. Buffers an incoming byte stream in a small FIFO and presents one character at a time to the matcher. For each character it strobes the matcher's per-character start, waits for rdy, and forwards any match position pair downstream over a valid/ready result channel. An end-of-stream beat drives the matcher's last input and always produces a final result record.

Parameters:
FIFO_DEPTH, 8, input FIFO entries (power of two, >=2)
START_CYCLES, 2, cycles eng_start is held high per character (>=1)
TIMEOUT, 1024, max WAIT cycles before abandoning a character (>=2)
POS_W, 32, width of start/end positions

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_char  in  8  character byte
in_eos  in  1  end-of-stream beat; in_char ignored
eng_start  out  1  per-character start strobe to compiled_regex reset input
eng_char  out  8  character to matcher
eng_last  out  1  end-of-stream flag to matcher
eng_rdy  in  1  matcher done
eng_match  in  1  matcher match flag, valid with eng_rdy
eng_start_pos  in  POS_W  match start, valid with eng_rdy
eng_end_pos  in  POS_W  match end, valid with eng_rdy
res_valid  out  1  result record valid
res_ready  in  1  result consumer ready
res_match  out  1  record carries a match
res_final  out  1  record produced by end-of-stream beat
res_start_pos  out  POS_W  captured start position
res_end_pos  out  POS_W  captured end position
busy  out  1  FSM not IDLE or FIFO not empty
timeout_err  out  1  sticky; a character was abandoned

Behaviour:
- Reset asserted: every output 0, including in_ready. FIFO emptied, FSM forced to IDLE, timeout counter cleared. Takes effect immediately, including mid-WAIT or mid-EMIT; any in-flight character or pending record is discarded.
- FIFO: 9-bit entries {eos,char}. in_ready = !full while reset is deasserted.
- Push on accepted beat. Pop only in IDLE. No fall-through: a beat pushed into an empty FIFO is popped at the earliest on the following edge.
- Full FIFO plus pop in the same cycle: no push that cycle, because in_ready was already low.
- FSM states: IDLE, KICK, WAIT, EMIT.
- IDLE: if FIFO not empty, pop, register eng_char/eng_last, load start counter = START_CYCLES, go to KICK.
- KICK: eng_start=1 (registered). Count down; after exactly START_CYCLES cycles high, go to WAIT with eng_start=0.
- WAIT: eng_rdy is sampled only in this state; rdy seen in KICK is ignored. Timeout counter increments each cycle.
  - eng_rdy=1 and (eng_match or eng_last): capture match/positions, set res_final=eng_last, go to EMIT.
  - eng_rdy=1 otherwise: go to IDLE.
  - Counter reaches TIMEOUT without rdy: set timeout_err, discard the character, go to IDLE. If that character was the EOS beat, no final record is emitted.
- EMIT: res_valid=1 with fields stable until res_valid & res_ready, then go to IDLE with res_valid=0 next cycle. When res_match=0, positions are 0.
- eng_char/eng_last hold their values from pop until the next pop.
- Latency: accept at edge t → pop at edge t+1 → eng_start high from t+1 for START_CYCLES cycles. Minimum accept-to-result = 2+START_CYCLES+matcher latency+1 cycles.
- One character in flight plus FIFO_DEPTH buffered. Stream restarts normally after an EOS beat.
- timeout_err is cleared only by reset.

Optional Feature:
REGEX_SEQ_STATS_EN: when defined, adds output ports stat_chars[31:0] and stat_matches[15:0].
- stat_chars counts non-EOS characters completed with rdy.
- stat_matches counts records with res_match=1.
- Both saturate at all-ones and are cleared by reset only.
When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Push 'a' (0x61); matcher model returns rdy 3 cycles after eng_start falls, match=0 → eng_char=0x61, eng_start high exactly 2 cycles, no res_valid, busy returns to 0.
- Push 'b'; model returns match=1, start=5, end=7; hold res_ready=0 for 4 cycles → res_valid stays 1 with res_match=1, res_final=0, positions 5/7 stable; drops the cycle after res_ready=1.
- Push EOS beat; model returns match=0 → eng_last=1; one record with res_final=1, res_match=0, positions 0.
- Model never asserts rdy after the first char; push 12 beats → 9 accepted (1 in flight + 8 buffered), in_ready=0 thereafter.
- TIMEOUT=16, model silent for first char then normal → timeout_err=1 after 16 WAIT cycles, second char processed normally, timeout_err stays 1.
- Assert reset during WAIT with FIFO holding 3 entries → all outputs 0 immediately. After release, FIFO empty, busy=0, in_ready=1, no result emitted.
